// File: rtl/mem_arbiter.sv
// Two-port arbiter that shares one line-wide memory between an instruction
// side and a data side, alternating grants on ties and idling one cycle after each response.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  last_grant_d;
    logic                  op_write;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  i_pending;
    logic                  d_pending;
    logic                  grant_i;
    logic                  grant_d;
    logic                  serving;

    assign i_pending = i_read | i_write;
    assign d_pending = d_read | d_write;

    // On a tie the side that did not win last time is granted.
    assign grant_i = (state == IDLE) && i_pending && (!d_pending || last_grant_d);
    assign grant_d = (state == IDLE) && d_pending && (!i_pending || !last_grant_d);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_d <= 1'b1;
            op_write     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else if (grant_i) begin
            last_grant_d <= 1'b0;
            op_write     <= i_write;
            addr_q       <= i_address;
            wdata_q      <= i_wdata;
        end else if (grant_d) begin
            last_grant_d <= 1'b1;
            op_write     <= d_write;
            addr_q       <= d_address;
            wdata_q      <= d_wdata;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves
        // next_state unassigned and no latch is inferred.
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_i)      next_state = SERVE_I;
                else if (grant_d) next_state = SERVE_D;
            end
            SERVE_I: if (pmem_resp) next_state = RECOVER;
            SERVE_D: if (pmem_resp) next_state = RECOVER;
            RECOVER: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        serving    = (state == SERVE_I) || (state == SERVE_D);
        pmem_read  = serving && !op_write;
        pmem_write = serving && op_write;
        i_resp     = pmem_resp && (state == SERVE_I);
        d_resp     = pmem_resp && (state == SERVE_D);
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_rdata      = pmem_rdata;
    assign d_rdata      = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected transactions are queued when a
// request is raised and compared when the arbiter strobes shared memory.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_address, d_address;
    logic [LW-1:0] i_wdata, d_wdata;
    logic          i_resp, d_resp;
    logic [LW-1:0] i_rdata, d_rdata;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_resp;
    logic [LW-1:0] pmem_rdata;

    typedef struct {
        bit            side_d;
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_read       (i_read),
        .i_write      (i_write),
        .i_address    (i_address),
        .i_wdata      (i_wdata),
        .i_resp       (i_resp),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_resp       (d_resp),
        .d_rdata      (d_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit side_d, input bit wr, input logic [AW-1:0] addr,
                        input logic [LW-1:0] wdata);
        txn_t t;
        t.side_d = side_d;
        t.wr     = wr;
        t.addr   = addr;
        t.wdata  = wdata;
        exp_q.push_back(t);
    endtask

    // Wait for a strobe, compare it to the queue head, respond after `delay`
    // cycles, and walk through the RECOVER and IDLE cycles that follow.
    task automatic serve(input logic [LW-1:0] rdata, input int delay, input bit drop);
        txn_t t;
        int   n;
        n = 0;
        while (!(pmem_read || pmem_write) && n < 20) begin
            tick();
            n++;
        end
        check("strobe_timeout", LW'(n < 20), LW'(1'b1));
        if (exp_q.size() == 0) begin
            check("queue_underflow", LW'(exp_q.size()), LW'(1));
            return;
        end
        t = exp_q.pop_front();
        if (n >= 20) return;
        check("pmem_write", LW'(pmem_write), LW'(t.wr));
        check("pmem_read", LW'(pmem_read), LW'(!t.wr));
        check("pmem_address", LW'(pmem_address), LW'(t.addr));
        if (t.wr) check("pmem_wdata", pmem_wdata, t.wdata);
        for (int k = 0; k < delay; k++) begin
            tick();
            check("addr_hold", LW'(pmem_address), LW'(t.addr));
            check("early_resp", LW'({i_resp, d_resp}), LW'(2'b00));
        end
        pmem_resp  = 1'b1;
        pmem_rdata = rdata;
        #1;
        check("i_resp", LW'(i_resp), LW'(!t.side_d));
        check("d_resp", LW'(d_resp), LW'(t.side_d));
        check("rdata", t.side_d ? d_rdata : i_rdata, rdata);
        tick();
        pmem_resp = 1'b0;
        if (drop) begin
            if (t.side_d) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end else begin
                i_read  = 1'b0;
                i_write = 1'b0;
            end
        end
        #1;
        check("recover_quiet", LW'({pmem_read, pmem_write, i_resp, d_resp}), LW'(4'b0000));
        tick();
        check("idle_gap", LW'({pmem_read, pmem_write}), LW'(2'b00));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        i_read     = 1'b0;
        i_write    = 1'b0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        i_address  = '0;
        d_address  = '0;
        i_wdata    = '0;
        d_wdata    = '0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        #1;
        check("rst_strobes", LW'({pmem_read, pmem_write}), LW'(2'b00));
        check("rst_resp", LW'({i_resp, d_resp}), LW'(2'b00));
        check("rst_addr", LW'(pmem_address), LW'(0));
        check("rst_wdata", pmem_wdata, LW'(0));
        tick();
        reset = 1'b0;
        tick();

        // Single instruction read with five-cycle memory latency.
        i_read    = 1'b1;
        i_address = 16'h0040;
        push(1'b0, 1'b0, 16'h0040, '0);
        #1;
        check("req_same_cycle", LW'({pmem_read, pmem_write}), LW'(2'b00));
        tick();
        check("strobe_t1", LW'(pmem_read), LW'(1'b1));
        serve({16{8'hA5}}, 5, 1'b1);

        // Simultaneous requests straight after reset: instruction side wins.
        do_reset();
        i_read    = 1'b1;
        i_address = 16'h0100;
        d_write   = 1'b1;
        d_address = 16'h2000;
        d_wdata   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        push(1'b0, 1'b0, 16'h0100, '0);
        push(1'b1, 1'b1, 16'h2000, d_wdata);
        tick();
        serve(128'h1111, 2, 1'b1);
        tick();
        check("d_strobe_r3", LW'(pmem_write), LW'(1'b1));
        serve(128'h2222, 1, 1'b1);

        // Both sides keep requesting: grants alternate I, D, I, D.
        do_reset();
        i_read    = 1'b1;
        i_address = 16'h0A00;
        d_read    = 1'b1;
        d_address = 16'h0B00;
        push(1'b0, 1'b0, 16'h0A00, '0);
        push(1'b1, 1'b0, 16'h0B00, '0);
        serve(128'hAAAA_0000, 1, 1'b0);
        i_address = 16'h0A10;
        push(1'b0, 1'b0, 16'h0A10, '0);
        serve(128'hBBBB_0000, 2, 1'b0);
        d_address = 16'h0B10;
        push(1'b1, 1'b0, 16'h0B10, '0);
        serve(128'hAAAA_1111, 0, 1'b1);
        serve(128'hBBBB_1111, 3, 1'b1);

        // Data address changes mid-service; the latched address must hold.
        d_write   = 1'b1;
        d_address = 16'h3000;
        d_wdata   = {4{32'hDEAD_BEEF}};
        push(1'b1, 1'b1, 16'h3000, d_wdata);
        tick();
        check("d_strobe_t1", LW'(pmem_write), LW'(1'b1));
        d_address = 16'h3010;
        d_wdata   = '0;
        serve(128'h3333, 4, 1'b1);

        // Reset during SERVE_D abandons the transaction without a response.
        d_read    = 1'b1;
        d_address = 16'h4000;
        tick();
        tick();
        check("serve_d_active", LW'(pmem_read), LW'(1'b1));
        reset     = 1'b1;
        pmem_resp = 1'b1;
        #1;
        check("rst_mid_strobes", LW'({pmem_read, pmem_write}), LW'(2'b00));
        check("rst_mid_resp", LW'({i_resp, d_resp}), LW'(2'b00));
        tick();
        pmem_resp = 1'b0;
        reset     = 1'b0;
        push(1'b1, 1'b0, 16'h4000, '0);
        serve(128'h4444, 1, 1'b1);

        // Stray memory response while idle is ignored.
        pmem_resp = 1'b1;
        #1;
        check("stray_resp", LW'({i_resp, d_resp}), LW'(2'b00));
        tick();
        check("stray_idle", LW'({pmem_read, pmem_write, i_resp, d_resp}), LW'(4'b0000));
        pmem_resp = 1'b0;
        tick();
        check("stray_after", LW'({pmem_read, pmem_write}), LW'(2'b00));

        // Read and write together on the instruction side become a write.
        i_read    = 1'b1;
        i_write   = 1'b1;
        i_address = 16'h5000;
        i_wdata   = {8{16'h5A5A}};
        push(1'b0, 1'b1, 16'h5000, i_wdata);
        tick();
        check("rw_write", LW'({pmem_read, pmem_write}), LW'(2'b01));
        serve(128'h5555, 1, 1'b1);

        check("queue_empty", LW'(exp_q.size()), LW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
